bm_sym_decoder: RTL
===================

BM_SYM_DECODER -- requirements
Module: bm_sym_decoder

Interface
REQ-001 SHALL have parameter SYM_BITS, default 2: symbol width in bits; fixed at 2 in this release.
REQ-002 SHALL have parameter DATA_SYMS, default 4: data symbols per frame; DATA_SYMS*SYM_BITS = 8.
REQ-003 SHALL have port clock, input, 1: rising-edge clock.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port sym_in, input, SYM_BITS: incoming encoded symbol.
REQ-006 SHALL have port sym_valid, input, 1: sym_in is valid this cycle.
REQ-007 SHALL have port data_ready, input, 1: downstream accepts data_out this cycle.
REQ-008 SHALL have port data_out, output, 8: decoded byte.
REQ-009 SHALL have port data_valid, output, 1: data_out holds an unconsumed byte.
REQ-010 SHALL have port frame_err, output, 1: one-cycle pulse on a framing or parity error.
REQ-011 SHALL have port overflow, output, 1: sticky flag; a completed byte was dropped.
REQ-012 SHALL have port in_frame, output, 1: high in every state except IDLE.

Function
REQ-013 SHALL sample symbols only on rising clock edges where sym_valid=1; sym_valid=0 cycles SHALL NOT change state, counter or shift register.
REQ-014 SHALL implement states IDLE, DATA, PARITY (only with PAR_CHECK_EN), STOP.
REQ-015 IDLE: symbol 2'b11 SHALL move to DATA, clear the symbol counter and clear the shift register; any other symbol SHALL be ignored without error.
REQ-016 DATA: each symbol SHALL shift in MSB-first, {shift[5:0], sym_in}; after the DATA_SYMS-th symbol SHALL move to PARITY if enabled, otherwise to STOP.
REQ-017 STOP: symbol 2'b00 SHALL commit the byte and return to IDLE; any other symbol SHALL pulse frame_err, discard the byte and return to IDLE.
REQ-018 SHALL drive data_valid high on the cycle after the accepted stop symbol; SHALL hold data_out stable while data_valid=1 and data_ready=0.
REQ-019 SHALL clear data_valid on the edge where data_valid=1 and data_ready=1.
REQ-020 If a byte commits while the holding register is full and not being consumed that cycle, SHALL keep the old byte, drop the new one, and set overflow until reset.
REQ-021 Commit in the same cycle as a consume SHALL load the new byte, keep data_valid=1 and SHALL NOT set overflow.
REQ-022 The symbol counter SHALL be ceil(log2(DATA_SYMS+1)) bits wide and SHALL NOT wrap inside a frame.
REQ-023 Symbol 2'b11 in DATA SHALL be treated as data, not as a restart.

Reset
REQ-024 On reset_n=0, SHALL asynchronously set state=IDLE, counter=0, shift=0, data_out=8'h00, data_valid=0, frame_err=0, overflow=0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no frame_err pulse; the first frame after release SHALL decode normally.

Configuration
REQ-026 With macro PAR_CHECK_EN defined, SHALL expect one parity symbol after the data symbols whose LSB is the even parity (XOR) of the 8 data bits; on mismatch SHALL pulse frame_err and return to IDLE; on match SHALL move to STOP.
REQ-027 Without PAR_CHECK_EN, the PARITY state and its logic SHALL be absent and the frame SHALL be start, DATA_SYMS data symbols, stop.

Structure
REQ-028 Symbol codes (SYM_START=2'b11, SYM_STOP=2'b00) and state encodings SHALL reside in shared package bm_sym_pkg.
REQ-029 The output holding register and its ready/valid logic SHALL be sub-module bm_sym_hold; the FSM and shifter SHALL stay in bm_sym_decoder.

Verification
REQ-030 Symbols 11,10,01,11,00,00 with data_ready=1 -> data_out=8'h9C, data_valid high one cycle, frame_err=0.
REQ-031 Symbols 11,01,01,01,01,10 -> frame_err pulse one cycle, data_valid stays 0, state IDLE.
REQ-032 Two valid frames (8'h55 then 8'hAA) with data_ready=0 -> data_out=8'h55 held, overflow=1; then data_ready=1 -> data_valid falls.
REQ-033 Frame 8'h3C with sym_valid toggled 0/1 between every symbol -> data_out=8'h3C, no error.
REQ-034 reset_n pulsed low after the second data symbol, then full frame 8'hF0 -> data_out=8'hF0, frame_err never pulses.
REQ-035 PAR_CHECK_EN: frame 8'h01 with parity symbol 00 -> frame_err; with parity symbol 01 -> data_out=8'h01.

Source files
------------

// File: rtl/bm_sym_pkg.sv
// bm_sym_pkg -- shared symbol codes and FSM state encoding for the
// bit-mapped symbol decoder.
// Optional feature macro: PAR_CHECK_EN (adds the PARITY state).
package bm_sym_pkg;

  localparam logic [1:0] SYM_START = 2'b11;
  localparam logic [1:0] SYM_STOP  = 2'b00;

`ifdef PAR_CHECK_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd3
  } state_e;
`endif

  // Even parity of a data byte (XOR of all bits).
  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/bm_sym_hold.sv
// bm_sym_hold -- single-entry output holding register with ready/valid.
// Ports:
//   clock, reset_n    : clock, async active-low reset
//   commit_i          : a completed byte is offered this cycle
//   commit_data_i     : the completed byte
//   ready_i           : downstream consumes data_o this cycle
//   data_o / valid_o  : held byte and its valid flag
//   overflow_o        : sticky, a committed byte was dropped
module bm_sym_hold
  import bm_sym_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         commit_i,
  input  logic [W-1:0] commit_data_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         overflow_o
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         ovf_q, ovf_d;

  // The slot is free when empty or being drained this very cycle.
  logic slot_free;
  assign slot_free = !valid_q || ready_i;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (commit_i) begin
      if (slot_free) begin
        data_d  = commit_data_i;
        valid_d = 1'b1;
      end else begin
        // Full and not draining: keep the old byte, drop the new one.
        ovf_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/bm_sym_decoder.sv
// bm_sym_decoder -- decodes framed 2-bit symbol streams into bytes.
// Frame: START(11), DATA_SYMS data symbols MSB-first, [parity], STOP(00).
// Optional feature macro: PAR_CHECK_EN -- one parity symbol after the data
// whose LSB is the even parity of the byte.
// Ports:
//   clock, reset_n         : clock, async active-low reset
//   sym_in, sym_valid      : incoming symbol and its qualifier
//   data_ready             : downstream accepts data_out
//   data_out, data_valid   : decoded byte and its valid flag
//   frame_err              : one-cycle pulse on stop/parity error
//   overflow               : sticky, a completed byte was dropped
//   in_frame               : FSM is not idle
module bm_sym_decoder
  import bm_sym_pkg::*;
#(
  parameter int SYM_BITS  = 2,
  parameter int DATA_SYMS = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [SYM_BITS-1:0] sym_in,
  input  logic                sym_valid,
  input  logic                data_ready,
  output logic [7:0]          data_out,
  output logic                data_valid,
  output logic                frame_err,
  output logic                overflow,
  output logic                in_frame
);

  localparam int BYTE_W = DATA_SYMS * SYM_BITS;
  localparam int CNT_W  = $clog2(DATA_SYMS + 1);
  localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(DATA_SYMS - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic                ferr_q, ferr_d;
  logic                commit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ferr_d  = 1'b0;
    commit  = 1'b0;
    if (sym_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (sym_in == SYM_START) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            shift_d = '0;
          end
        end
        ST_DATA: begin
          // START inside DATA is just data; the counter stops at DATA_SYMS.
          shift_d = {shift_q[BYTE_W-SYM_BITS-1:0], sym_in};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_SYM) begin
`ifdef PAR_CHECK_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
`ifdef PAR_CHECK_EN
        ST_PARITY: begin
          if (sym_in[0] != even_par(shift_q)) begin
            ferr_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          state_d = ST_IDLE;
          if (sym_in == SYM_STOP) commit = 1'b1;
          else                    ferr_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
    end
  end

  bm_sym_hold #(.W(BYTE_W)) u_hold (
    .clock         (clock),
    .reset_n       (reset_n),
    .commit_i      (commit),
    .commit_data_i (shift_q),
    .ready_i       (data_ready),
    .data_o        (data_out),
    .valid_o       (data_valid),
    .overflow_o    (overflow)
  );

  assign frame_err = ferr_q;
  assign in_frame  = (state_q != ST_IDLE);

endmodule
